// File: rtl/zr_dm_port_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | zr_dm_port_arb : round-robin, single-outstanding arbiter that shares the     |
// | debug-module ICB target between core instr/data ports. Optional response  |
// | timeout enabled by `ZR_DM_ARB_TIMEOUT_EN.              Rev 1.0             |
// +----------------------------------------------------------------------------+
module zr_dm_port_arb #(
  parameter int AW      = 12,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  input  logic          data_req_i,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [31:0]   data_addr_i,
  input  logic [31:0]   data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic [31:0]   data_rdata_o,
  output logic          data_err_o,
  output logic          icb_cmd_valid_o,
  input  logic          icb_cmd_ready_i,
  output logic [AW-1:0] icb_cmd_addr_o,
  output logic          icb_cmd_read_o,
  output logic [31:0]   icb_cmd_wdata_o,
  input  logic          icb_rsp_valid_i,
  output logic          icb_rsp_ready_o,
  input  logic [31:0]   icb_rsp_rdata_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_RSP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_last_instr;
  logic            r_port_instr;
  logic            r_read;
  logic            r_err;
  logic [AW-1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;

  logic            w_idle;
  logic            w_gnt_instr;
  logic            w_gnt_data;
  logic            w_sub_wr;
  logic            w_timeout;
  logic            w_done;
  logic            w_unused;

  // Grant is suppressed while rst is high so reset outputs are all zero.
  assign w_idle      = (r_state == S_IDLE) && !rst;
  assign w_gnt_instr = w_idle && instr_req_i && (!data_req_i || !r_last_instr);
  assign w_gnt_data  = w_idle && data_req_i && (!instr_req_i || r_last_instr);
  assign w_sub_wr    = data_we_i && (data_be_i != 4'hF);

`ifdef ZR_DM_ARB_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;

  assign w_timeout = (r_tmo_cnt == 16'(TIMEOUT - 1));
  assign w_unused  = ^{instr_addr_i[31:AW], data_addr_i[31:AW]};

  always_ff @(posedge clk) begin
    if (rst || (r_state != S_RSP)) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_unused  = (^{instr_addr_i[31:AW], data_addr_i[31:AW]}) ^ (TIMEOUT == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_instr <= 1'b0;
      r_port_instr <= 1'b0;
      r_read       <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_instr || w_gnt_data) begin
            r_last_instr <= w_gnt_instr;
            r_port_instr <= w_gnt_instr;
            r_addr       <= w_gnt_instr ? instr_addr_i[AW-1:0] : data_addr_i[AW-1:0];
            r_read       <= w_gnt_instr | ~data_we_i;
            r_wdata      <= w_gnt_instr ? 32'h0 : data_wdata_i;
            r_rdata      <= '0;
            // No byte mask on the ICB: partial writes complete locally with an error.
            if (w_gnt_data && w_sub_wr) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_err   <= 1'b0;
              r_state <= S_CMD;
            end
          end
        end
        S_CMD: begin
          if (icb_cmd_ready_i) begin
            r_state <= S_RSP;
          end
        end
        S_RSP: begin
          if (icb_rsp_valid_i) begin
            r_rdata <= r_read ? icb_rsp_rdata_i : 32'h0;
            r_err   <= 1'b0;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_done          = (r_state == S_DONE);
  assign instr_gnt_o     = w_gnt_instr;
  assign data_gnt_o      = w_gnt_data;
  assign instr_rvalid_o  = w_done && r_port_instr;
  assign instr_rdata_o   = instr_rvalid_o ? r_rdata : 32'h0;
  assign data_rvalid_o   = w_done && !r_port_instr;
  assign data_rdata_o    = data_rvalid_o ? r_rdata : 32'h0;
  assign data_err_o      = data_rvalid_o && r_err;
  assign icb_cmd_valid_o = (r_state == S_CMD);
  assign icb_cmd_addr_o  = r_addr;
  assign icb_cmd_read_o  = r_read;
  assign icb_cmd_wdata_o = r_wdata;
  assign icb_rsp_ready_o = 1'b1;
  assign busy_o          = (r_state != S_IDLE);

endmodule
`default_nettype wire
